// File: rtl/country_road_car_detector.sv
// country_road_car_detector: synchronizes, debounces and hold-extends the country-road loop sensor,
// counts qualified arrivals and latches a stuck-on fault that keeps the request asserted.
module country_road_car_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int MAX_ON_CYCLES   = 1000,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   CLOCK,
  input  logic                   CLEAR,
  input  logic                   SENSOR_RAW,
  input  logic                   FAULT_ACK,
  output logic                   CAR_ON_COUNTRY_ROAD,
  output logic [COUNT_WIDTH-1:0] CAR_COUNT,
  output logic                   SENSOR_FAULT
);
  // One counter serves qcnt, oncnt and hcnt since only one is live per state.
  localparam int CW = $clog2(MAX_ON_CYCLES + HOLD_CYCLES + DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, QUALIFY, PRESENT, HOLD, FAULT} state_t;
  state_t state_q, state_d;
  logic sync_q, sensor_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic req_q, req_d, fault_q, fault_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    case (state_q)
      IDLE:
        if (sensor_q) begin
          state_d = QUALIFY;
          cnt_d   = CW'(1);
        end
      QUALIFY:
        if (!sensor_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = PRESENT;
          cnt_d   = CW'(1);
          count_d = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
        end else cnt_d = cnt_q + CW'(1);
      PRESENT:
        if (!sensor_q) begin
          state_d = HOLD;
          cnt_d   = CW'(1);
        end else if (cnt_q == CW'(MAX_ON_CYCLES - 1)) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      HOLD:
        if (sensor_q) begin
          state_d = PRESENT;
          cnt_d   = CW'(1);
        end else if (cnt_q == CW'(HOLD_CYCLES)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      FAULT:
        if (FAULT_ACK && !sensor_q) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    req_d   = state_d inside {PRESENT, HOLD, FAULT};
    fault_d = state_d == FAULT;
  end
  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      sync_q   <= 1'b0;
      sensor_q <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync_q   <= SENSOR_RAW;
      sensor_q <= sync_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      req_q    <= req_d;
      fault_q  <= fault_d;
    end
  end
  assign CAR_ON_COUNTRY_ROAD = req_q;
  assign CAR_COUNT           = count_q;
  assign SENSOR_FAULT        = fault_q;
endmodule
